crc_serial_engine: RTL
======================

Name: crc_serial_engine

Overview:
- Parametrised serial CRC generator and checker for the USB data path. It is the successor to the fixed CRC16 shift-register checker.
- Accepts one bit per enabled clock, framed by sop/eop, in either of two modes selected per packet:
  - GEN: computes the CRC and then shifts the CRC bits out serially.
  - CHK: compares the final register against the residue and flags pass or fail.
- Sits between the bit-unstuffer/stuffer and the packet FSMs. Instantiated for CRC16 (data packets) and CRC5 (token packets).

Parameters:
WIDTH, 16, CRC register width (supported 5..32)
POLY, 16'h8005, generator polynomial without the implicit x^WIDTH term
INIT, 16'hFFFF, register value loaded at sop
XOR_OUT, 16'hFFFF, final XOR applied to crc_o and to transmitted CRC bits
RESIDUE, 16'h800D, register value after a good packet including its CRC (CRC5 use: 5'h0C)
REFLECT_OUT, 1, 1 = crc_o is bit-reversed before XOR_OUT

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous reset, active-high (asserted = 1)
mode  in  1  0 = CHK, 1 = GEN; sampled only on the sop cycle
sop  in  1  first bit of packet; valid only when bit_valid=1
eop  in  1  last data bit of packet; valid only when bit_valid=1
bit_valid  in  1  data_in is valid this cycle
data_in  in  1  serial data bit, already in line order (LSB-first for USB)
tx_ready  in  1  downstream accepts tx_bit this cycle
tx_bit  out  1  CRC bit being appended (GEN)
tx_valid  out  1  tx_bit valid
tx_last  out  1  final CRC bit
crc_o  out  WIDTH  finished CRC value, held until next sop
crc_valid  out  1  one-cycle pulse, crc_o/crc_ok/crc_err updated
crc_ok  out  1  CHK pass, held until next sop
crc_err  out  1  CHK fail or framing error, held until next sop
busy  out  1  state != IDLE

Behaviour:
- Reset values of all outputs are 0; the register resets to INIT and the state to IDLE.
- Register update per accepted bit:
  - fb = r[WIDTH-1] ^ data_in
  - r <= {r[WIDTH-2:0],1'b0} ^ (fb ? POLY : 0)
- States: IDLE, DATA, APPEND, DONE.
- IDLE:
  - sop & bit_valid: load INIT, then apply the update with that bit in the same cycle.
  - Latch mode. Clear crc_ok and crc_err.
  - Go to DATA; if eop is also set (1-bit packet), go to the end handling directly.
- DATA:
  - Each bit_valid cycle applies the update.
  - On eop & bit_valid (after the update), the next state depends on the latched mode:
    - CHK goes to DONE.
    - GEN goes to APPEND with cnt=0.
  - Stalls (bit_valid=0) hold all state. There is no timeout.
- APPEND (GEN only):
  - tx_valid=1 and tx_bit = r[WIDTH-1] ^ XOR_OUT[WIDTH-1-cnt].
  - On tx_ready: shift r left with zero fill and no feedback, then cnt++.
  - tx_last=1 when cnt==WIDTH-1. After tx_last & tx_ready, go to DONE.
  - crc_o is snapshotted on APPEND entry.
- DONE (one cycle):
  - Pulse crc_valid.
  - CHK: crc_ok = (r==RESIDUE); crc_err = ~crc_ok.
  - crc_o = (REFLECT_OUT ? bitrev(r_at_eop) : r_at_eop) ^ XOR_OUT.
  - Go to IDLE.
- Latency:
  - CHK: crc_valid is exactly 2 clocks after the eop cycle (DONE register, then output register).
  - GEN: the first tx_valid is 1 clock after eop.
- sop seen in DATA: abort the current packet, pulse crc_valid with crc_err=1, and restart with the new sop bit in the same cycle. No bit is lost.
- Any input in APPEND: bit_valid is ignored in APPEND (upstream must hold off; busy=1). A sop arriving in APPEND is dropped and sets crc_err at DONE.
- eop without prior sop (IDLE): ignored, no outputs.
- n_rst mid-packet: immediate return to IDLE. tx_valid drops asynchronously and no crc_valid pulse is produced.
- Width rules:
  - All parameter constants are truncated to WIDTH.
  - cnt width is $clog2(WIDTH).

Decomposition:
- Shared package crc_pkg:
  - state enum (IDLE, DATA, APPEND, DONE).
  - USB constants CRC16_POLY/INIT/RESIDUE and CRC5_POLY=5'h05/INIT=5'h1F/RESIDUE=5'h0C.
  - bitrev function.
- One natural sub-module, crc_lfsr_step: the combinational single-bit update, reused for the future parallel variant.

Test Plan:
1. GEN, CRC16 defaults, ASCII "123456789" fed LSB-first per byte (72 bits) -> crc_o=16'hB4C8, then 16 tx bits with tx_ready=1, tx_last on the 16th.
2. Loopback: GEN output bits from test 1 appended to the same 72 bits, fed in CHK -> crc_ok=1, crc_err=0, crc_valid 2 clocks after eop.
3. CHK with data 136'hAA..AA followed by CRC 16'hFFFF -> crc_err=1, crc_ok=0. Repeat with bit 40 of the good packet flipped -> crc_err=1.
4. CRC5 instance (WIDTH=5, POLY=5'h05, INIT=5'h1F, RESIDUE=5'h0C, XOR_OUT=5'h1F): GEN on 11-bit token addr=7'h15, endp=4'hE -> append 5 bits, then CHK loopback -> crc_ok=1.
5. Stalls and backpressure: bit_valid toggled 50%, tx_ready low 3 cycles mid-APPEND -> results identical to tests 1 and 2, tx_bit held stable while tx_ready=0.
6. n_rst asserted after 40 data bits -> all outputs 0 next edge, no crc_valid. Then a new sop in the same cycle as eop of a packet, and a sop mid-DATA -> crc_err pulse, and the restarted packet passes.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared CRC engine definitions: FSM state codes, USB CRC constants and a
// width-aware bit-reversal helper.
package crc_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_APPEND = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [15:0] CRC16_POLY    = 16'h8005;
  localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUE = 16'h800D;

  localparam logic [4:0] CRC5_POLY    = 5'h05;
  localparam logic [4:0] CRC5_INIT    = 5'h1F;
  localparam logic [4:0] CRC5_RESIDUE = 5'h0C;

  // Reverses the low w bits of v; bits above w come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
    logic [31:0] src;
    logic [31:0] o;
    src = v;
    o   = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) begin
        o   = {o[30:0], src[0]};
        src = src >> 1;
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/crc_lfsr_step.sv
// One serial CRC step: shift the register by one input bit with polynomial
// feedback.
module crc_lfsr_step #(
  parameter int              WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY = '0
) (
  input  logic [WIDTH-1:0] r_in,
  input  logic             bit_in,
  output logic [WIDTH-1:0] r_out
);

  logic fb;

  always_comb begin
    fb    = r_in[WIDTH-1] ^ bit_in;
    r_out = {r_in[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
  end

endmodule

// File: rtl/crc_serial_engine.sv
// Serial CRC generator/checker: one bit per bit_valid cycle framed by sop/eop,
// GEN appends the CRC serially, CHK compares the final register to the residue.
module crc_serial_engine
  import crc_pkg::*;
#(
  parameter int          WIDTH       = 16,
  parameter logic [31:0] POLY        = 32'(CRC16_POLY),
  parameter logic [31:0] INIT        = 32'(CRC16_INIT),
  parameter logic [31:0] XOR_OUT     = 32'hFFFF,
  parameter logic [31:0] RESIDUE     = 32'(CRC16_RESIDUE),
  parameter bit          REFLECT_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             mode,
  input  logic             sop,
  input  logic             eop,
  input  logic             bit_valid,
  input  logic             data_in,
  input  logic             tx_ready,
  output logic             tx_bit,
  output logic             tx_valid,
  output logic             tx_last,
  output logic [WIDTH-1:0] crc_o,
  output logic             crc_valid,
  output logic             crc_ok,
  output logic             crc_err,
  output logic             busy
);

  localparam int               CW       = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] POLY_W   = POLY[WIDTH-1:0];
  localparam logic [WIDTH-1:0] INIT_W   = INIT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] XOR_W    = XOR_OUT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RES_W    = RESIDUE[WIDTH-1:0];
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] fmt_crc(input logic [WIDTH-1:0] r);
    logic [31:0] rv;
    rv = bitrev(32'(r), WIDTH);
    return (REFLECT_OUT ? rv[WIDTH-1:0] : r) ^ XOR_W;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] r_eop_q, r_eop_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             drop_q, drop_d;
  logic [WIDTH-1:0] crc_o_q, crc_o_d;
  logic             crc_valid_q, crc_valid_d;
  logic             crc_ok_q, crc_ok_d;
  logic             crc_err_q, crc_err_d;

  logic             start, accept, end_mode;
  logic [WIDTH-1:0] step_in, step_out, xor_sh;

  // A sop is honoured everywhere except APPEND, where the shifter is busy.
  assign start    = bit_valid & sop & (state_q != ST_APPEND);
  assign accept   = start | (bit_valid & (state_q == ST_DATA));
  assign step_in  = start ? INIT_W : r_q;
  assign end_mode = start ? mode : mode_q;

  crc_lfsr_step #(.WIDTH(WIDTH), .POLY(POLY_W)) u_step (
    .r_in  (step_in),
    .bit_in(data_in),
    .r_out (step_out)
  );

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    r_eop_d     = r_eop_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    drop_d      = drop_q;
    crc_o_d     = crc_o_q;
    crc_valid_d = 1'b0;
    crc_ok_d    = crc_ok_q;
    crc_err_d   = crc_err_q;

    if (state_q == ST_APPEND) begin
      if (bit_valid && sop) drop_d = 1'b1;
      if (tx_ready) begin
        r_d   = {r_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = ST_DONE;
      end
    end
    if (state_q == ST_DONE) state_d = ST_IDLE;

    if (start) begin
      mode_d    = mode;
      drop_d    = 1'b0;
      crc_ok_d  = 1'b0;
      crc_err_d = 1'b0;
    end
    // sop inside DATA aborts the packet in flight; the new bit still counts.
    if (start && state_q == ST_DATA) begin
      crc_valid_d = 1'b1;
      crc_err_d   = 1'b1;
    end

    if (accept) begin
      r_d     = step_out;
      state_d = ST_DATA;
      if (eop) begin
        r_eop_d = step_out;
        cnt_d   = '0;
        if (end_mode) begin
          state_d = ST_APPEND;
          crc_o_d = fmt_crc(step_out);
        end else begin
          state_d = ST_DONE;
        end
      end
    end

    // DONE results take priority over a back-to-back sop in the same cycle.
    if (state_q == ST_DONE) begin
      crc_valid_d = 1'b1;
      crc_o_d     = fmt_crc(r_eop_q);
      if (!mode_q) begin
        crc_ok_d  = (r_q == RES_W);
        crc_err_d = (r_q != RES_W);
      end else begin
        crc_ok_d  = 1'b0;
        crc_err_d = drop_q;
      end
    end
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_q     <= ST_IDLE;
      r_q         <= INIT_W;
      r_eop_q     <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      drop_q      <= 1'b0;
      crc_o_q     <= '0;
      crc_valid_q <= 1'b0;
      crc_ok_q    <= 1'b0;
      crc_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      r_eop_q     <= r_eop_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      drop_q      <= drop_d;
      crc_o_q     <= crc_o_d;
      crc_valid_q <= crc_valid_d;
      crc_ok_q    <= crc_ok_d;
      crc_err_q   <= crc_err_d;
    end
  end

  assign xor_sh    = XOR_W << cnt_q;
  assign tx_valid  = (state_q == ST_APPEND);
  assign tx_bit    = tx_valid & (r_q[WIDTH-1] ^ xor_sh[WIDTH-1]);
  assign tx_last   = tx_valid & (cnt_q == CNT_LAST);
  assign busy      = (state_q != ST_IDLE);
  assign crc_o     = crc_o_q;
  assign crc_valid = crc_valid_q;
  assign crc_ok    = crc_ok_q;
  assign crc_err   = crc_err_q;

endmodule
